spi_fifo_ctrl: RTL and testbench
================================

# spi_fifo_ctrl

- Buffers and schedules 16-bit words for the SPI readout path.
- Two producers (requester 0 and requester 1) post words. A round-robin arbiter writes them into a DEPTH-entry circular FIFO.
- The SPI readout block requests words with its one-cycle `flag_rd_fifo` pulse (falling edge of CS). This block answers with a registered word one cycle later, in time for the SPI block's delayed load strobe.
- Status outputs report occupancy and dropped words.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `EMPTY_WORD`, 16'h0000: word returned when a read hits an empty FIFO.
- `sys_clk` in 1: system clock; all logic on rising edge.
- `sys_rst` in 1: reset, asynchronous, active-high.
- `req0_data` in 16: requester 0 word.
- `req0_valid` in 1: one-cycle strobe; `req0_data` is valid.
- `req1_data` in 16: requester 1 word.
- `req1_valid` in 1: one-cycle strobe; `req1_data` is valid.
- `flag_rd_fifo` in 1: one-cycle read request from the SPI side.
- `fifo_data` out 16: registered read word; reset 16'h0000.
- `flag_fifo_data` out 1: one-cycle pulse when `fifo_data` is updated; reset 0.
- `level` out $clog2(DEPTH)+1: stored entry count; reset 0.
- `empty` out 1: level==0; reset 1.
- `full` out 1: level==DEPTH; reset 0.
- `ovf` out 1: sticky drop flag; reset 0.
- `clr_ovf` in 1: clears `ovf`.

## Operation
- **Holding registers.** Each requester has a one-word holding register `hold_n` with occupied bit `hv_n`.
  - A `reqN_valid` strobe loads `hold_n` and sets `hv_n` when the register is empty.
  - It also loads when the holding word is written to the FIFO in the same cycle.
  - Otherwise the new word is discarded, `hold_n` is kept, and `ovf` is set.
- **Arbiter.** State `last` (0/1) holds the last granted requester; reset value is 1, so requester 0 wins the first tie.
  - If only one `hv` is set, that requester is granted.
  - If both are set, the requester != `last` is granted.
  - `last` updates only on an actual write.
- **Write.** A granted word is written when `!full || pop`. The write clears that requester's `hv` and advances `wptr` modulo DEPTH.
  - Held words wait indefinitely while the FIFO is full; a held word is never lost.
- **Read.** A request (`flag_rd_fifo`=1) has two cases:
  - If the FIFO is not empty, it pops: `fifo_data` <= mem[rptr], `rptr` advances modulo DEPTH.
  - If the FIFO is empty, `fifo_data` <= `EMPTY_WORD`.
  - In both cases `flag_fifo_data` pulses.
- **Simultaneous events.**
  - Push and pop in the same cycle leave `level` unchanged. On a full FIFO both are allowed.
  - A push to an empty FIFO is not readable in the same cycle; the read returns `EMPTY_WORD`.
- **Overflow flag.** `clr_ovf` has priority below a same-cycle set: if set and clear coincide, `ovf`=1.
- **Reset.** Reset mid-operation clears the pointers, `level`, `hv_n`, `ovf` and `flag_fifo_data`, and sets `last`=1. Memory contents are don't-care.

## Timing
- Read latency: `flag_rd_fifo` high in cycle N gives `fifo_data`/`flag_fifo_data` valid in cycle N+1. The SPI block loads at the end of N+1.
- Requester latency: strobe in cycle N loads `hold` at the end of N. The FIFO write happens at the earliest at the end of N+1, and the word is readable from cycle N+2.
- Two requesters strobing every cycle are served alternately; sustained throughput is one write per cycle total.
- `level`, `empty` and `full` are registered and reflect the state after the last edge.
- Back-to-back `flag_rd_fifo` pulses, every cycle, are supported.

## Configuration
- Macro: `SPI_FIFO_CTRL_TAG_EN`.
- **Defined:** the stored word is {source id, data[14:0]}, where bit 15 is 0 for requester 0 and 1 for requester 1. Bit 15 of `reqN_data` is ignored. `EMPTY_WORD` is unchanged.
- **Undefined:** the full 16-bit `reqN_data` is stored unmodified.

## Test plan
- **Reset then order.** After reset, push req0 16'h1234, then req1 16'hABCD. Two `flag_rd_fifo` pulses give `fifo_data` 16'h1234 then 16'hABCD, each with a one-cycle `flag_fifo_data` pulse one cycle after its request.
- **Empty read.** `flag_rd_fifo` on an empty FIFO gives `fifo_data`=EMPTY_WORD and `flag_fifo_data` pulses; `level` stays 0.
- **Tie arbitration.** Both requesters strobe in the same cycle with 16'h0001/16'h0002, repeated three times. Read-out order is 1,2,1,2,1,2 and no `ovf`.
- **Full and overflow.**
  - Fill DEPTH=8, then strobe req0 16'h00AA: it is held and `full`=1.
  - A second req0 strobe with 16'h00BB sets `ovf`; 16'h00AA survives and 16'h00BB is lost.
  - One pop admits 16'h00AA; `level` stays 8.
  - `clr_ovf` clears `ovf`.
- **Pointer wrap.** Push and pop 20 sequential words 16'h0000..16'h0013 one at a time. Read-out matches the input, `level` never exceeds 1, and the pointers wrap twice.
- **Async reset mid-stream.** Assert `sys_rst` between edges with level=5. All outputs take reset values immediately, and the next read returns EMPTY_WORD.

Source files
------------

// File: rtl/spi_fifo_ctrl.sv
// spi_fifo_ctrl: two-requester round-robin FIFO answering one-cycle SPI read pulses with a registered word.
// Define SPI_FIFO_CTRL_TAG_EN to replace bit 15 of each stored word with its source id.
module spi_fifo_ctrl #(
  parameter int          DEPTH      = 8,
  parameter logic [15:0] EMPTY_WORD = 16'h0000
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [15:0]              req0_data,
  input  logic                     req0_valid,
  input  logic [15:0]              req1_data,
  input  logic                     req1_valid,
  input  logic                     flag_rd_fifo,
  output logic [15:0]              fifo_data,
  output logic                     flag_fifo_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     ovf,
  input  logic                     clr_ovf
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   hold0_q, hold0_d, hold1_q, hold1_d, fifo_data_q, fifo_data_d, wdata;
  logic          hv0_q, hv0_d, hv1_q, hv1_d, last_q, last_d, ovf_q, ovf_d, flag_q, flag_d;
  logic          pop, gnt, wr, keep0, keep1, drop;
  always_comb begin
    pop = flag_rd_fifo && level_q != '0;
    gnt = hv1_q && (!hv0_q || !last_q);
    wr = (hv0_q || hv1_q) && (level_q != LW'(DEPTH) || pop);
`ifdef SPI_FIFO_CTRL_TAG_EN
    wdata = {gnt, gnt ? hold1_q[14:0] : hold0_q[14:0]};
`else
    wdata = gnt ? hold1_q : hold0_q;
`endif
    // a holding register freed by this cycle's write can take a new word at once
    keep0 = hv0_q && !(wr && !gnt);
    keep1 = hv1_q && !(wr && gnt);
    drop = (req0_valid && keep0) || (req1_valid && keep1);
    hold0_d = (req0_valid && !keep0) ? req0_data : hold0_q;
    hold1_d = (req1_valid && !keep1) ? req1_data : hold1_q;
    hv0_d = keep0 || req0_valid;
    hv1_d = keep1 || req1_valid;
    last_d = wr ? gnt : last_q;
    ovf_d = drop || (ovf_q && !clr_ovf);
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    level_d = level_q + LW'(wr) - LW'(pop);
    fifo_data_d = flag_rd_fifo ? (pop ? mem_q[rptr_q] : EMPTY_WORD) : fifo_data_q;
    flag_d = flag_rd_fifo;
  end
  always_ff @(posedge sys_clk) begin
    if (wr) mem_q[wptr_q] <= wdata;
  end
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      hold0_q <= '0;
      hold1_q <= '0;
      hv0_q <= 1'b0;
      hv1_q <= 1'b0;
      last_q <= 1'b1;
      ovf_q <= 1'b0;
      fifo_data_q <= '0;
      flag_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      hold0_q <= hold0_d;
      hold1_q <= hold1_d;
      hv0_q <= hv0_d;
      hv1_q <= hv1_d;
      last_q <= last_d;
      ovf_q <= ovf_d;
      fifo_data_q <= fifo_data_d;
      flag_q <= flag_d;
    end
  end
  assign fifo_data = fifo_data_q;
  assign flag_fifo_data = flag_q;
  assign level = level_q;
  assign empty = level_q == '0;
  assign full = level_q == LW'(DEPTH);
  assign ovf = ovf_q;
endmodule

// File: tb/tb_spi_fifo_ctrl.sv
// tb_spi_fifo_ctrl: directed and random checks of spi_fifo_ctrl against a queue-based reference model.
module tb_spi_fifo_ctrl;
  localparam int          DEPTH = 8;
  localparam logic [15:0] EW    = 16'h0000;
  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] req0_data = '0, req1_data = '0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, flag_rd_fifo = 1'b0, clr_ovf = 1'b0;
  logic [15:0] fifo_data;
  logic        flag_fifo_data, empty, full, ovf;
  logic [$clog2(DEPTH):0] level;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] q[$];
  logic [15:0] h0, h1, m_data;
  bit h0v, h1v, last, m_ovf, m_flag;

  spi_fifo_ctrl #(.DEPTH(DEPTH), .EMPTY_WORD(EW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0_data(req0_data), .req0_valid(req0_valid),
    .req1_data(req1_data), .req1_valid(req1_valid),
    .flag_rd_fifo(flag_rd_fifo), .fifo_data(fifo_data), .flag_fifo_data(flag_fifo_data),
    .level(level), .empty(empty), .full(full), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [15:0] tw(bit src, logic [15:0] d);
`ifdef SPI_FIFO_CTRL_TAG_EN
    return {src, d[14:0]};
`else
    return d;
`endif
  endfunction

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("fifo_data", fifo_data, m_data);
    chk("flag_fifo_data", 16'(flag_fifo_data), 16'(m_flag));
    chk("level", 16'(level), 16'(q.size()));
    chk("empty", 16'(empty), 16'(q.size() == 0));
    chk("full", 16'(full), 16'(q.size() == DEPTH));
    chk("ovf", 16'(ovf), 16'(m_ovf));
  endtask

  task automatic model_reset();
    q.delete();
    h0v = 0; h1v = 0; last = 1; m_ovf = 0; m_data = EW; m_flag = 0;
  endtask

  // one clock: apply inputs, advance the model by the behavioural rules, compare after the edge
  task automatic cyc(bit v0, logic [15:0] d0, bit v1, logic [15:0] d1, bit rd, bit clr);
    bit pop, g, wr;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    flag_rd_fifo = rd; clr_ovf = clr;
    pop = rd && q.size() > 0;
    g = (h0v && h1v) ? !last : h1v;
    wr = (h0v || h1v) && (q.size() < DEPTH || pop);
    if (rd) m_data = pop ? q.pop_front() : EW;
    m_flag = rd;
    if (wr) begin
      q.push_back(g ? tw(1, h1) : tw(0, h0));
      last = g;
      if (g) h1v = 0; else h0v = 0;
    end
    if (clr) m_ovf = 0;
    if (v0) begin if (!h0v) begin h0 = d0; h0v = 1; end else m_ovf = 1; end
    if (v1) begin if (!h1v) begin h1 = d1; h1v = 1; end else m_ovf = 1; end
    @(posedge sys_clk);
    #1;
    req0_valid = 0; req1_valid = 0; flag_rd_fifo = 0; clr_ovf = 0;
    check_all();
  endtask

  task automatic idle(); cyc(0, '0, 0, '0, 0, 0); endtask
  task automatic rd();   cyc(0, '0, 0, '0, 1, 0); endtask

  initial begin
    model_reset();
    #12;
    check_all();
    sys_rst = 0;
    // ordering across requesters
    cyc(1, 16'h1234, 0, '0, 0, 0);
    cyc(0, '0, 1, 16'hABCD, 0, 0);
    idle(); idle();
    rd();
    chk("order0", fifo_data, tw(0, 16'h1234));
    chk("order0_flag", 16'(flag_fifo_data), 16'd1);
    idle();
    chk("flag_one_cycle", 16'(flag_fifo_data), 16'd0);
    rd();
    chk("order1", fifo_data, tw(1, 16'hABCD));
    // empty read
    rd();
    chk("empty_read", fifo_data, EW);
    chk("empty_level", 16'(level), 16'd0);
    // tie arbitration
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h0001, 1, 16'h0002, 0, 0);
      idle(); idle();
    end
    for (int i = 0; i < 6; i++) begin
      rd();
      chk("tie_order", fifo_data, (i % 2 == 0) ? tw(0, 16'h0001) : tw(1, 16'h0002));
    end
    chk("tie_no_ovf", 16'(ovf), 16'd0);
    // full and overflow
    for (int i = 0; i < DEPTH; i++) cyc(1, 16'(i), 0, '0, 0, 0);
    idle();
    cyc(1, 16'h00AA, 0, '0, 0, 0);
    idle();
    chk("full_flag", 16'(full), 16'd1);
    chk("full_level", 16'(level), 16'(DEPTH));
    cyc(1, 16'h00BB, 0, '0, 0, 0);
    chk("ovf_set", 16'(ovf), 16'd1);
    rd();
    chk("pop_full", fifo_data, tw(0, 16'h0000));
    chk("level_kept", 16'(level), 16'(DEPTH));
    cyc(0, '0, 0, '0, 0, 1);
    chk("ovf_clr", 16'(ovf), 16'd0);
    for (int i = 1; i < DEPTH; i++) rd();
    rd();
    chk("held_word", fifo_data, tw(0, 16'h00AA));
    rd();
    chk("lost_word", fifo_data, EW);
    // pointer wrap
    for (int i = 0; i < 20; i++) begin
      cyc(1, 16'(i), 0, '0, 0, 0);
      idle();
      chk("wrap_level", 16'(level <= 1), 16'd1);
      rd();
      chk("wrap_data", fifo_data, tw(0, 16'(i)));
    end
    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0));
    for (int i = 0; i < 12; i++) rd();
    // asynchronous reset with level 5
    for (int i = 0; i < 6; i++) cyc(0, '0, 1, 16'h0100 + 16'(i), 0, 0);
    idle();
    rd();
    chk("pre_reset_level", 16'(level), 16'd5);
    #2 sys_rst = 1;
    #1;
    chk("rst_level", 16'(level), 16'd0);
    chk("rst_empty", 16'(empty), 16'd1);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    chk("rst_flag", 16'(flag_fifo_data), 16'd0);
    chk("rst_data", fifo_data, 16'h0000);
    #2 sys_rst = 0;
    model_reset();
    rd();
    chk("post_rst_read", fifo_data, EW);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
